// File: rtl/irrigation_delay_timer.sv
// rtl/irrigation_delay_timer.sv - prescaled loadable delay timer with one-shot and periodic modes
// Defining IRRIGATION_TIMER_PAUSE_EN adds a pause input that freezes a running count.
module irrigation_delay_timer #(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
`ifdef IRRIGATION_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] reload;
    logic             mode_q;
    logic             run_en;

`ifdef IRRIGATION_TIMER_PAUSE_EN
    assign run_en = (state == RUN) && !pause;
`else
    assign run_en = (state == RUN);
`endif

    assign tick_out = run_en && (prescaler == PS_MAX);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            reload    <= '0;
            mode_q    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // stop wins over everything, including a coinciding terminal count
                state     <= IDLE;
                remaining <= '0;
                prescaler <= '0;
            end else if (start) begin
                prescaler <= '0;
                if (load_val == '0) begin
                    done      <= 1'b1;
                    state     <= IDLE;
                    remaining <= '0;
                end else begin
                    remaining <= load_val;
                    reload    <= load_val;
                    mode_q    <= mode;
                    state     <= RUN;
                end
            end else if (run_en) begin
                prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + PS_W'(1);
                if (tick_out) begin
                    if (remaining > CNT_W'(1)) begin
                        remaining <= remaining - CNT_W'(1);
                    end else begin
                        done <= 1'b1;
                        if (mode_q) begin
                            remaining <= reload;
                        end else begin
                            remaining <= '0;
                            state     <= IDLE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_irrigation_delay_timer.sv
// tb/tb_irrigation_delay_timer.sv - self-checking bench for irrigation_delay_timer
// Directed steps plus random traffic checked against a cycle-count arithmetic model.
module tb_irrigation_delay_timer;

    localparam int P = 4;
`ifdef IRRIGATION_TIMER_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       pause_v;
    logic       mode;
    logic [7:0] load_val;
    logic       tick_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int tests_run = 0;
    int failed    = 0;

    // model: timer described by unpaused RUN cycles elapsed since the last (re)start
    bit m_busy;
    bit m_done;
    bit m_per;
    int m_n;
    int m_cnt;

    irrigation_delay_timer #(.PRESCALE(P), .CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .stop      (stop),
`ifdef IRRIGATION_TIMER_PAUSE_EN
        .pause     (pause_v),
`endif
        .mode      (mode),
        .load_val  (load_val),
        .tick_out  (tick_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_rem();
        if (!m_busy) return 0;
        return m_n - ((m_cnt / P) % m_n);
    endfunction

    function automatic bit exp_tick();
        return m_busy && !(PAUSE_ON && pause_v) && ((m_cnt % P) == P - 1);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_per = 0; m_n = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit s, input bit sp, input bit pa, input bit m, input int lv);
        bit nd = 0;
        if (sp) begin
            m_busy = 0; m_cnt = 0;
        end else if (s) begin
            m_cnt = 0;
            if (lv == 0) begin
                m_busy = 0; nd = 1;
            end else begin
                m_busy = 1; m_n = lv; m_per = m;
            end
        end else if (m_busy && !pa) begin
            m_cnt++;
            if (m_cnt % (m_n * P) == 0) begin
                nd = 1;
                if (!m_per) begin
                    m_busy = 0; m_cnt = 0;
                end
            end
        end
        m_done = nd;
    endtask

    // called at posedge+1; drives inputs for the coming edge and checks both sides of it
    task automatic step(input bit s, input bit sp, input bit pa, input bit m, input logic [7:0] lv);
        start = s; stop = sp; pause_v = pa && PAUSE_ON; mode = m; load_val = lv;
        #1;
        chk("tick_out", tick_out, exp_tick());
        @(posedge clk);
        model_edge(s, sp, pa && PAUSE_ON, m, lv);
        #1;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("remaining", remaining, exp_rem());
        start = 0; stop = 0;
    endtask

    initial begin
        int first_done;
        int n_done;
        int r;
        rstn = 0; start = 0; stop = 0; pause_v = 0; mode = 0; load_val = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", tick_out, 0);
        chk("rst_remaining", remaining, 0);
        rstn = 1;

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'd0);

        // one-shot N=3: done at edge 12 after the start edge
        first_done = -1;
        step(1, 0, 0, 0, 8'd3);
        for (int i = 1; i <= 14; i++) begin
            step(0, 0, 0, 0, 8'd0);
            if (done && first_done < 0) first_done = i;
        end
        chk("oneshot_done_edge", first_done, 12);
        chk("oneshot_busy_end", busy, 0);

        // periodic N=2 over 40 edges: pulses at 8,16,24,32,40
        first_done = -1; n_done = 0;
        step(1, 0, 0, 1, 8'd2);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0, 8'd0);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
        chk("periodic_first", first_done, 8);
        chk("periodic_count", n_done, 5);
        chk("periodic_busy", busy, 1);
        step(0, 1, 0, 0, 8'd0);

        // one-shot N=5 stopped at cycle 10, then stop+start together
        step(1, 0, 0, 0, 8'd5);
        for (int i = 1; i < 10; i++) step(0, 0, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0);
        chk("stop_remaining", remaining, 0);
        chk("stop_busy", busy, 0);
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 8'd0);
        step(1, 1, 0, 0, 8'd5);
        chk("stop_start_busy", busy, 0);

        // zero load: done one cycle, never busy
        step(1, 0, 0, 0, 8'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        step(0, 0, 0, 0, 8'd0);
        chk("zero_done_clear", done, 0);

        // asynchronous reset mid-run with remaining = 4
        step(1, 0, 0, 0, 8'd6);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 8'd0);
        chk("pre_reset_remaining", remaining, 4);
        #3 rstn = 0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_tick", tick_out, 0);
        chk("async_remaining", remaining, 0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1;

        if (PAUSE_ON) begin
            // pause cycles 3..8 push done from edge 8 to edge 14
            first_done = -1;
            step(1, 0, 0, 0, 8'd2);
            for (int i = 1; i <= 16; i++) begin
                step(0, 0, (i >= 3 && i <= 8), 0, 8'd0);
                if (done && first_done < 0) first_done = i;
            end
            chk("pause_done_edge", first_done, 14);
        end

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 63));
            step(r < 4, r == 63, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
